bus_requester: RTL and testbench



---
 rtl/bus_pkg.sv | 19 +
 rtl/bus_requester.sv | 206 ++++++++++++++++++++
 tb/tb_bus_requester.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_pkg.sv
// bus_pkg: types and constants shared by the bus requester and the bus arbiter.
package bus_pkg;

  // Requester phases: wait for command, arbitrate, address phase, data phase, hand bus back.
  typedef enum logic [2:0] {
    IDLE,
    REQ,
    ADDR,
    DATA,
    RELEASE
  } bus_req_state_t;

  // Width of the saturating abort counter.
  localparam int ERR_CNT_W = 8;

  // Default wait-cycle limit; the arbiter uses the same value for its own timeout.
  localparam int DEFAULT_TIMEOUT = 255;

endpackage

// File: rtl/bus_requester.sv
// bus_requester: master-side bus stage in front of the arbiter. Turns one burst-write
// command into a BARQ/BAGD arbitration, an address phase and a data phase, then
// releases the bus for one cycle. Aborts (grant loss, optional wait timeout) are
// counted in a saturating err_cnt.
// Optional feature: define BUS_REQUESTER_TIMEOUT_EN to add the 16-bit wait counter
// that aborts a burst after TIMEOUT idle cycles in REQ, ADDR or DATA.
module bus_requester
  import bus_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 16,
  parameter int TIMEOUT   = DEFAULT_TIMEOUT,
  localparam int LEN_W    = $clog2(MAX_BURST + 1)
) (
  input  logic                 clk,
  input  logic                 clrn,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [ADDR_W-1:0]    cmd_addr,
  input  logic [LEN_W-1:0]     cmd_len,
  input  logic                 dat_valid,
  output logic                 dat_ready,
  input  logic [DATA_W-1:0]    dat_in,
  output logic                 BARQ,
  input  logic                 BAGD,
  output logic                 AddressValid,
  output logic [ADDR_W-1:0]    bus_addr,
  input  logic                 TargetReady,
  output logic                 DataStrobe,
  output logic [DATA_W-1:0]    bus_data,
  output logic                 done,
  output logic                 abort,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  // A zero-length command still moves one beat; oversized commands are clipped.
  function automatic logic [LEN_W-1:0] norm_len(input logic [LEN_W-1:0] len);
    if (len == '0) begin
      return LEN_W'(1);
    end
    if (int'(len) > MAX_BURST) begin
      return LEN_W'(MAX_BURST);
    end
    return len;
  endfunction

  // Abort counter holds at all-ones instead of wrapping.
  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] value);
    return (value == '1) ? value : value + 1'b1;
  endfunction

  bus_req_state_t       state;
  bus_req_state_t       state_nxt;
  logic [LEN_W-1:0]     beats;
  logic [ADDR_W-1:0]    addr_q;
  logic                 barq_q;
  logic                 av_q;
  logic                 done_q;
  logic                 abort_q;
  logic [ERR_CNT_W-1:0] err_q;
  logic                 strobe;
  logic                 load;
  logic                 done_nxt;
  logic                 abort_nxt;
  logic                 timed_out;

`ifdef BUS_REQUESTER_TIMEOUT_EN
  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

  logic [15:0] wait_cnt;

  // Wait counter: restarts on every state change and every beat, counts stalled cycles.
  always_ff @(posedge clk) begin
    if (!clrn) begin
      wait_cnt <= '0;
    end else if ((state_nxt != state) || strobe) begin
      wait_cnt <= '0;
    end else if ((state == REQ) || (state == ADDR) || (state == DATA)) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // The current stalled cycle is the TIMEOUT-th one, so this edge gives up.
  assign timed_out = (wait_cnt == WAIT_LAST);
`else
  // Without the wait counter the block waits for grant and target indefinitely.
  assign timed_out = 1'b0;
`endif

  // Next-state decode; grant loss has priority over any progress in ADDR and DATA.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    done_nxt  = 1'b0;
    abort_nxt = 1'b0;
    strobe    = (state == DATA) && dat_valid && TargetReady && BAGD;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          load      = 1'b1;
          state_nxt = REQ;
        end
      end
      REQ: begin
        if (BAGD) begin
          state_nxt = ADDR;
        end else if (timed_out) begin
          abort_nxt = 1'b1;
          state_nxt = RELEASE;
        end
      end
      ADDR: begin
        if (!BAGD || timed_out && !TargetReady) begin
          abort_nxt = 1'b1;
          state_nxt = RELEASE;
        end else if (TargetReady) begin
          state_nxt = DATA;
        end
      end
      DATA: begin
        if (!BAGD) begin
          abort_nxt = 1'b1;
          state_nxt = RELEASE;
        end else if (strobe) begin
          if (beats == LEN_W'(1)) begin
            done_nxt  = 1'b1;
            state_nxt = RELEASE;
          end
        end else if (timed_out) begin
          abort_nxt = 1'b1;
          state_nxt = RELEASE;
        end
      end
      RELEASE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!clrn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Registered bus-facing controls, decoded from the state being entered.
  always_ff @(posedge clk) begin
    if (!clrn) begin
      barq_q  <= 1'b0;
      av_q    <= 1'b0;
      done_q  <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      barq_q  <= (state_nxt == REQ) || (state_nxt == ADDR) || (state_nxt == DATA);
      av_q    <= (state_nxt == ADDR);
      done_q  <= done_nxt;
      abort_q <= abort_nxt;
    end
  end

  // Remaining-beat counter: loaded with the normalised length, one down per strobe.
  always_ff @(posedge clk) begin
    if (!clrn) begin
      beats <= '0;
    end else if (load) begin
      beats <= norm_len(cmd_len);
    end else if (strobe) begin
      beats <= beats - 1'b1;
    end
  end

  // Burst start address; only observed through the gated bus_addr output.
  always_ff @(posedge clk) begin
    if (load) begin
      addr_q <= cmd_addr;
    end
  end

  // Saturating abort counter.
  always_ff @(posedge clk) begin
    if (!clrn) begin
      err_q <= '0;
    end else if (abort_nxt) begin
      err_q <= sat_inc(err_q);
    end
  end

  assign cmd_ready    = (state == IDLE);
  assign BARQ         = barq_q;
  assign AddressValid = av_q;
  assign bus_addr     = av_q ? addr_q : '0;
  assign DataStrobe   = strobe;
  assign dat_ready    = strobe;
  assign bus_data     = strobe ? dat_in : '0;
  assign done         = done_q;
  assign abort        = abort_q;
  assign err_cnt      = err_q;

endmodule

// File: tb/tb_bus_requester.sv
// tb_bus_requester: directed stimulus for bus_requester with a behavioural reference
// model compared every cycle, plus literal expectations for each scenario.
// Build with BUS_REQUESTER_TIMEOUT_EN defined to exercise the wait timeout.
module tb_bus_requester;

  localparam int AW = 8;
  localparam int DW = 8;
  localparam int MB = 16;
  localparam int LW = $clog2(MB + 1);
  localparam int TO = 5;

  logic          clk = 1'b0;
  logic          clrn;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [AW-1:0] cmd_addr;
  logic [LW-1:0] cmd_len;
  logic          dat_valid;
  logic          dat_ready;
  logic [DW-1:0] dat_in;
  logic          barq;
  logic          bagd;
  logic          av;
  logic [AW-1:0] bus_addr;
  logic          tr;
  logic          ds;
  logic [DW-1:0] bus_data;
  logic          done;
  logic          abort;
  logic [7:0]    err_cnt;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  bus_requester #(
    .ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .clrn(clrn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .dat_valid(dat_valid), .dat_ready(dat_ready),
    .dat_in(dat_in), .BARQ(barq), .BAGD(bagd), .AddressValid(av), .bus_addr(bus_addr),
    .TargetReady(tr), .DataStrobe(ds), .bus_data(bus_data), .done(done), .abort(abort),
    .err_cnt(err_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model. Phase: 0 idle, 1 arbitrating, 2 address, 3 data, 4 release.
  int            m_ph = 0;
  int            m_left = 0;
  int            m_err = 0;
  int            m_wait = 0;
  logic [AW-1:0] m_addr = '0;
  bit            m_done = 1'b0;
  bit            m_abort = 1'b0;

  function automatic int clamp_len(input int l);
    if (l == 0) return 1;
    if (l > MB) return MB;
    return l;
  endfunction

  task automatic m_finish(input bit aborted);
    m_ph   = 4;
    m_wait = 0;
    if (aborted) begin
      m_abort = 1'b1;
      if (m_err < 255) m_err++;
    end else begin
      m_done = 1'b1;
    end
  endtask

  task automatic m_stall();
`ifdef BUS_REQUESTER_TIMEOUT_EN
    m_wait++;
    if (m_wait >= TO) m_finish(1'b1);
`endif
  endtask

  always @(posedge clk) begin : model
    bit s;
    s = (m_ph == 3) && dat_valid && tr && bagd;
    m_done  = 1'b0;
    m_abort = 1'b0;
    if (!clrn) begin
      m_ph = 0; m_left = 0; m_err = 0; m_wait = 0;
    end else begin
      case (m_ph)
        0: if (cmd_valid) begin
             m_addr = cmd_addr; m_left = clamp_len(int'(cmd_len)); m_ph = 1; m_wait = 0;
           end
        1: if (bagd) begin m_ph = 2; m_wait = 0; end else m_stall();
        2: if (!bagd) m_finish(1'b1);
           else if (tr) begin m_ph = 3; m_wait = 0; end
           else m_stall();
        3: if (!bagd) m_finish(1'b1);
           else if (s) begin
             m_left--; m_wait = 0;
             if (m_left == 0) m_finish(1'b0);
           end else m_stall();
        default: m_ph = 0;
      endcase
    end
  end

  // Burst monitor, updated by the compare process.
  int            mon_str = 0;
  int            mon_done = 0;
  int            mon_abort = 0;
  logic [DW-1:0] mon_last = '0;
  logic [AW-1:0] mon_addr = '0;

  always @(negedge clk) begin : compare
    logic s;
    if (chk_en) begin
      s = (m_ph == 3) && dat_valid && tr && bagd;
      chk("cmd_ready", cmd_ready, m_ph == 0);
      chk("BARQ", barq, (m_ph >= 1) && (m_ph <= 3));
      chk("AddressValid", av, m_ph == 2);
      chk("bus_addr", bus_addr, (m_ph == 2) ? m_addr : '0);
      chk("DataStrobe", ds, s);
      chk("dat_ready", dat_ready, s);
      chk("bus_data", bus_data, s ? dat_in : '0);
      chk("done", done, m_done);
      chk("abort", abort, m_abort);
      chk("err_cnt", err_cnt, m_err);
      if (ds) begin mon_str++; mon_last = bus_data; end
      if (av) mon_addr = bus_addr;
      if (done) mon_done++;
      if (abort) mon_abort++;
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One command; grant after gdly arbitration cycles; grant dropped once drop_at beats
  // have moved (-1 = never); optional dat_valid pattern 1,0,1,1,1.
  task automatic run(input logic [AW-1:0] a, input logic [LW-1:0] l, input int gdly,
                     input int drop_at, input bit tog, input logic [DW-1:0] d,
                     output int ns, output int nd, output int na, output int lat);
    int s0, d0, a0;
    bit fin;
    bit pat [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    s0 = mon_str; d0 = mon_done; a0 = mon_abort;
    for (int k = 0; k < 50 && !cmd_ready; k++) cyc(1);
    cmd_valid = 1'b1; cmd_addr = a; cmd_len = l; dat_valid = 1'b1; dat_in = d; bagd = 1'b0;
    cyc(1);
    cmd_valid = 1'b0;
    cyc(gdly);
    lat = gdly;
    bagd = 1'b1;
    fin = 1'b0;
    for (int k = 0; k < 100 && !fin; k++) begin
      cyc(1);
      lat++;
      if (done || abort) begin
        fin = 1'b1;
      end else begin
        if (tog) dat_valid = pat[k % 5];
        dat_in = d + DW'(k - 1);
        if (drop_at >= 0 && (mon_str - s0) >= drop_at) bagd = 1'b0;
      end
    end
    chk("burst_end_seen", fin, 1'b1);
    chk("barq_low_in_release", barq, 1'b0);
    bagd = 1'b0; dat_valid = 1'b0;
    cyc(1);
    chk("idle_after_release", cmd_ready, 1'b1);
    chk("barq_low_after_release", barq, 1'b0);
    ns = mon_str - s0; nd = mon_done - d0; na = mon_abort - a0;
  endtask

  initial begin
    int ns, nd, na, lat, a0, tcnt;
    clrn = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0;
    dat_valid = 1'b0; dat_in = '0; bagd = 1'b0; tr = 1'b0;
    cyc(2);
    chk_en = 1'b1;
    chk("rst_cmd_ready", cmd_ready, 1'b1);
    chk("rst_barq", barq, 1'b0);
    chk("rst_av", av, 1'b0);
    chk("rst_strobe", ds, 1'b0);
    chk("rst_done_abort", {done, abort}, 2'b00);
    chk("rst_err", err_cnt, 8'd0);
    clrn = 1'b1; tr = 1'b1;
    cyc(1);

    // Single beat, grant two cycles after BARQ.
    run(8'h3C, LW'(1), 2, -1, 1'b0, 8'hA5, ns, nd, na, lat);
    chk("t1_strobes", ns, 1);
    chk("t1_data", mon_last, 8'hA5);
    chk("t1_addr", mon_addr, 8'h3C);
    chk("t1_done", nd, 1);
    chk("t1_err", err_cnt, 8'd0);

    // Best-case latency, command accept to done.
    run(8'h55, LW'(1), 0, -1, 1'b0, 8'h11, ns, nd, na, lat);
    chk("best_latency", lat, 3);

    // Four beats with gaps in dat_valid.
    run(8'h10, LW'(4), 1, -1, 1'b1, 8'h20, ns, nd, na, lat);
    chk("t2_strobes", ns, 4);
    chk("t2_done", nd, 1);
    chk("t2_abort", na, 0);

    // Length normalisation.
    run(8'h20, LW'(0), 0, -1, 1'b0, 8'h30, ns, nd, na, lat);
    chk("len0_strobes", ns, 1);
    run(8'h30, LW'(20), 0, -1, 1'b0, 8'h40, ns, nd, na, lat);
    chk("len20_strobes", ns, 16);
    chk("len20_done", nd, 1);

    // Grant lost after two of four beats.
    run(8'h40, LW'(4), 0, 2, 1'b0, 8'h50, ns, nd, na, lat);
    chk("drop_strobes", ns, 2);
    chk("drop_abort", na, 1);
    chk("drop_no_done", nd, 0);
    chk("drop_err", err_cnt, 8'd1);

    // Grant never arrives.
    a0 = mon_abort;
    cmd_valid = 1'b1; cmd_addr = 8'h77; cmd_len = LW'(2); bagd = 1'b0;
    cyc(1);
    cmd_valid = 1'b0;
`ifdef BUS_REQUESTER_TIMEOUT_EN
    tcnt = 0;
    for (int k = 0; k < 40 && !abort; k++) begin
      cyc(1);
      tcnt++;
    end
    chk("timeout_cycles", tcnt, TO);
    chk("timeout_abort", mon_abort - a0, 1);
    chk("timeout_err", err_cnt, 8'd2);
    cyc(2);
`else
    cyc(30);
    chk("no_timeout_barq", barq, 1'b1);
    chk("no_timeout_abort", mon_abort - a0, 0);
    clrn = 1'b0;
    cyc(1);
    clrn = 1'b1;
    chk("no_timeout_reset_idle", cmd_ready, 1'b1);
`endif

    // Saturation of the abort counter.
    a0 = mon_abort;
    for (int i = 0; i < 300; i++) begin
      run(AW'(i), LW'(4), 0, 0, 1'b0, 8'h00, ns, nd, na, lat);
    end
    chk("sat_aborts", mon_abort - a0, 300);
    chk("sat_err", err_cnt, 8'd255);

    // Reset in the middle of a data phase.
    cmd_valid = 1'b1; cmd_addr = 8'h99; cmd_len = LW'(8); bagd = 1'b1; dat_valid = 1'b1;
    dat_in = 8'hC3;
    cyc(1);
    cmd_valid = 1'b0;
    cyc(3);
    chk("mid_in_data", ds, 1'b1);
    clrn = 1'b0;
    cyc(1);
    chk("mid_rst_cmd_ready", cmd_ready, 1'b1);
    chk("mid_rst_barq_av", {barq, av}, 2'b00);
    chk("mid_rst_strobe", {ds, dat_ready}, 2'b00);
    chk("mid_rst_done_abort", {done, abort}, 2'b00);
    chk("mid_rst_bus", {bus_addr, bus_data}, 16'h0000);
    chk("mid_rst_err", err_cnt, 8'd0);
    clrn = 1'b1; bagd = 1'b0; dat_valid = 1'b0;
    cyc(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
